// File: rtl/sel_pkg.sv
`default_nettype none
// =============================================================================
// Package    : sel_pkg
// Description: State encodings and field-slice helper for selection_capture.
// Revision   : 1.0
// =============================================================================
package sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // Lowest bit of field idx inside the flattened selection vector.
    function automatic int field_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage : sel_pkg
`default_nettype wire

// File: rtl/sel_timeout_timer.sv
`default_nettype none
// =============================================================================
// Module     : sel_timeout_timer
// Description: Saturating idle counter with clear/enable; flags the last cycle.
// Revision   : 1.0
// =============================================================================
module sel_timeout_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic clr,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    if (TIMEOUT_CYC > 0) begin : g_enabled
        localparam int TW = $clog2(TIMEOUT_CYC + 1);
        localparam logic [TW-1:0] c_LAST = TW'(TIMEOUT_CYC - 1);

        logic [TW-1:0] r_count;

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                r_count <= '0;
            end else if (i_clear) begin
                r_count <= '0;
            end else if (i_enable && r_count != c_LAST) begin
                r_count <= r_count + TW'(1);
            end
        end

        assign o_expired = (r_count == c_LAST);
    end else begin : g_disabled
        logic w_unused;
        assign w_unused  = clk ^ clr ^ i_clear ^ i_enable;
        assign o_expired = 1'b0;
    end

endmodule : sel_timeout_timer
`default_nettype wire

// File: rtl/selection_capture.sv
`default_nettype none
// =============================================================================
// Module     : selection_capture
// Description: Keypad selection register bank with valid/ack, cancel, timeout.
// Revision   : 1.0
// =============================================================================
module selection_capture
    import sel_pkg::*;
#(
    parameter int CODE_W      = 2,
    parameter int NFIELDS     = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic [CODE_W-1:0]           code,
    input  logic                        code_valid,
    input  logic                        cancel,
    input  logic                        ack,
    output logic [NFIELDS*CODE_W-1:0]   sel_flat,
    output logic [$clog2(NFIELDS):0]    field_idx,
    output logic                        busy,
    output logic                        sel_valid,
    output logic                        timeout_p,
    output logic                        drop_p
);

    localparam int FIW = $clog2(NFIELDS) + 1;
    localparam logic [FIW-1:0] c_LAST_IDX = FIW'(NFIELDS - 1);

    state_t         r_state;
    logic [FIW-1:0] r_field_idx;
    logic           r_busy;
    logic           r_sel_valid;
    logic           r_timeout_p;
    logic           r_drop_p;

    logic w_expired;
    logic w_first;
    logic w_next;
    logic w_timeout;
    logic w_clear_all;
    logic w_timer_clear;

    assign w_first       = (r_state == ST_IDLE) && code_valid && !cancel;
    assign w_next        = (r_state == ST_COLLECT) && code_valid && !cancel;
    assign w_timeout     = (r_state == ST_COLLECT) && !code_valid && !cancel && w_expired;
    assign w_clear_all   = cancel || w_timeout;
    assign w_timer_clear = (r_state != ST_COLLECT) || cancel || code_valid || w_expired;

    sel_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .clr       (clr),
        .i_clear   (w_timer_clear),
        .i_enable  (r_state == ST_COLLECT),
        .o_expired (w_expired)
    );

    // Field 0 is loaded by the first code; the rest by field_idx in COLLECT.
    for (genvar gi = 0; gi < NFIELDS; gi++) begin : g_field
        logic [CODE_W-1:0] r_field;

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                r_field <= '0;
            end else if (w_clear_all) begin
                r_field <= '0;
            end else if (w_first) begin
                r_field <= (gi == 0) ? code : '0;
            end else if (w_next && r_field_idx == FIW'(gi)) begin
                r_field <= code;
            end
        end

        assign sel_flat[field_lo(gi, CODE_W) +: CODE_W] = r_field;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_field_idx <= '0;
            r_busy      <= 1'b0;
            r_sel_valid <= 1'b0;
            r_timeout_p <= 1'b0;
            r_drop_p    <= 1'b0;
        end else begin
            r_timeout_p <= 1'b0;
            r_drop_p    <= 1'b0;
            if (cancel) begin
                r_state     <= ST_IDLE;
                r_field_idx <= '0;
                r_busy      <= 1'b0;
                r_sel_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (code_valid) begin
                            if (NFIELDS == 1) begin
                                r_state     <= ST_HOLD;
                                r_sel_valid <= 1'b1;
                            end else begin
                                r_state     <= ST_COLLECT;
                                r_field_idx <= FIW'(1);
                                r_busy      <= 1'b1;
                            end
                        end
                    end
                    ST_COLLECT: begin
                        if (code_valid) begin
                            if (r_field_idx == c_LAST_IDX) begin
                                r_state     <= ST_HOLD;
                                r_sel_valid <= 1'b1;
                                r_field_idx <= '0;
                                r_busy      <= 1'b0;
                            end else begin
                                r_field_idx <= r_field_idx + FIW'(1);
                            end
                        end else if (w_expired) begin
                            r_state     <= ST_IDLE;
                            r_field_idx <= '0;
                            r_busy      <= 1'b0;
                            r_timeout_p <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (code_valid) begin
                            r_drop_p <= 1'b1;
                        end else if (ack) begin
                            r_state     <= ST_IDLE;
                            r_sel_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_field_idx <= '0;
                        r_busy      <= 1'b0;
                        r_sel_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign field_idx = r_field_idx;
    assign busy      = r_busy;
    assign sel_valid = r_sel_valid;
    assign timeout_p = r_timeout_p;
    assign drop_p    = r_drop_p;

endmodule : selection_capture
`default_nettype wire

// File: tb/tb_selection_capture.sv
`default_nettype none
// =============================================================================
// Module     : tb_selection_capture
// Description: Scoreboard bench for two selection_capture configurations.
// Revision   : 1.0
// =============================================================================
module tb_selection_capture;

    localparam int A_W = 2;
    localparam int A_N = 2;
    localparam int B_W = 4;
    localparam int B_N = 3;
    localparam int TMO = 8;
    localparam int K_SEL = 0;
    localparam int K_TMO = 1;
    localparam int K_DROP = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          at;
    } ev_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    logic [A_W-1:0]     a_code = '0;
    logic               a_cv = 1'b0, a_cancel = 1'b0, a_ack = 1'b0;
    logic [A_N*A_W-1:0] a_sel;
    logic [1:0]         a_idx;
    logic               a_busy, a_sv, a_tp, a_dp;

    logic [B_W-1:0]     b_code = '0;
    logic               b_cv = 1'b0, b_cancel = 1'b0, b_ack = 1'b0;
    logic [B_N*B_W-1:0] b_sel;
    logic [2:0]         b_idx;
    logic               b_busy, b_sv, b_tp, b_dp;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    ev_t qa[$];
    ev_t qb[$];

    selection_capture #(.CODE_W(A_W), .NFIELDS(A_N), .TIMEOUT_CYC(TMO)) dut_a (
        .clk(clk), .clr(clr), .code(a_code), .code_valid(a_cv), .cancel(a_cancel),
        .ack(a_ack), .sel_flat(a_sel), .field_idx(a_idx), .busy(a_busy),
        .sel_valid(a_sv), .timeout_p(a_tp), .drop_p(a_dp)
    );

    selection_capture #(.CODE_W(B_W), .NFIELDS(B_N), .TIMEOUT_CYC(TMO)) dut_b (
        .clk(clk), .clr(clr), .code(b_code), .code_valid(b_cv), .cancel(b_cancel),
        .ack(b_ack), .sel_flat(b_sel), .field_idx(b_idx), .busy(b_busy),
        .sel_valid(b_sv), .timeout_p(b_tp), .drop_p(b_dp)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pop_a(input int kind, input logic [31:0] data);
        ev_t e;
        if (qa.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_event actual=%0d required=none", kind);
        end else begin
            e = qa.pop_front();
            chk("a_ev_kind", kind, e.kind);
            chk("a_ev_data", data, e.data);
            chk("a_ev_cycle", cyc, e.at);
        end
    endtask

    task automatic pop_b(input int kind, input logic [31:0] data);
        ev_t e;
        if (qb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_event actual=%0d required=none", kind);
        end else begin
            e = qb.pop_front();
            chk("b_ev_kind", kind, e.kind);
            chk("b_ev_data", data, e.data);
            chk("b_ev_cycle", cyc, e.at);
        end
    endtask

    // Monitors: every visible output event must match the head of its queue.
    logic a_sv_d = 1'b0;
    logic b_sv_d = 1'b0;
    always @(negedge clk) begin
        if (a_sv && !a_sv_d) pop_a(K_SEL, 32'(a_sel));
        if (a_tp) pop_a(K_TMO, 32'd0);
        if (a_dp) pop_a(K_DROP, 32'd0);
        a_sv_d = a_sv;
        if (b_sv && !b_sv_d) pop_b(K_SEL, 32'(b_sel));
        if (b_tp) pop_b(K_TMO, 32'd0);
        if (b_dp) pop_b(K_DROP, 32'd0);
        b_sv_d = b_sv;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic cv, input logic [A_W-1:0] c, input logic can, input logic ak);
        a_cv = cv; a_code = c; a_cancel = can; a_ack = ak;
        tick();
        a_cv = 1'b0; a_code = '0; a_cancel = 1'b0; a_ack = 1'b0;
    endtask

    task automatic b_drive(input logic cv, input logic [B_W-1:0] c, input logic ak);
        b_cv = cv; b_code = c; b_ack = ak;
        tick();
        b_cv = 1'b0; b_code = '0; b_ack = 1'b0;
    endtask

    task automatic a_push(input int kind, input logic [31:0] data, input int dly);
        ev_t e;
        e.kind = kind; e.data = data; e.at = cyc + dly;
        qa.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t eb;
        // Reset state
        tick();
        tick();
        chk("rst_sel", 32'(a_sel), 0);
        chk("rst_idx", 32'(a_idx), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_sv", 32'(a_sv), 0);
        chk("rst_pulses", 32'({a_tp, a_dp}), 0);
        clr = 1'b0;
        tick();

        // Normal two-code sequence
        a_drive(1'b1, 2'b10, 1'b0, 1'b0);
        chk("t1_busy", 32'(a_busy), 1);
        chk("t1_idx1", 32'(a_idx), 1);
        chk("t1_live", 32'(a_sel), 32'b0010);
        repeat (3) tick();
        a_push(K_SEL, 32'b0110, 1);
        a_drive(1'b1, 2'b01, 1'b0, 1'b0);
        chk("t1_sv", 32'(a_sv), 1);
        chk("t1_busy0", 32'(a_busy), 0);
        chk("t1_idx0", 32'(a_idx), 0);
        a_drive(1'b0, 2'b00, 1'b0, 1'b1);
        chk("t1_ack_sv", 32'(a_sv), 0);
        chk("t1_ack_sel", 32'(a_sel), 32'b0110);
        tick();

        // Timeout after silence, then a code landing on the timeout cycle
        a_push(K_TMO, 32'd0, 9);
        a_drive(1'b1, 2'b11, 1'b0, 1'b0);
        repeat (7) tick();
        chk("t2_pre_busy", 32'(a_busy), 1);
        tick();
        chk("t2_tp", 32'(a_tp), 1);
        chk("t2_sel", 32'(a_sel), 0);
        chk("t2_idx", 32'(a_idx), 0);
        chk("t2_busy", 32'(a_busy), 0);
        tick();
        a_drive(1'b1, 2'b11, 1'b0, 1'b0);
        repeat (7) tick();
        a_push(K_SEL, 32'b0011, 1);
        a_drive(1'b1, 2'b00, 1'b0, 1'b0);
        chk("t2b_sv", 32'(a_sv), 1);
        chk("t2b_tp", 32'(a_tp), 0);
        a_drive(1'b0, 2'b00, 1'b0, 1'b1);

        // Cancel mid-collection, then cancel together with a code
        a_drive(1'b1, 2'b01, 1'b0, 1'b0);
        a_drive(1'b0, 2'b00, 1'b1, 1'b0);
        chk("t3_sel", 32'(a_sel), 0);
        chk("t3_busy", 32'(a_busy), 0);
        repeat (10) tick();
        a_drive(1'b1, 2'b11, 1'b1, 1'b0);
        chk("t3b_sel", 32'(a_sel), 0);
        chk("t3b_busy", 32'(a_busy), 0);
        chk("t3b_idx", 32'(a_idx), 0);
        repeat (10) tick();

        // HOLD overrun, then ack+cancel
        a_drive(1'b1, 2'b10, 1'b0, 1'b0);
        a_push(K_SEL, 32'b1110, 1);
        a_drive(1'b1, 2'b11, 1'b0, 1'b0);
        a_push(K_DROP, 32'd0, 1);
        a_drive(1'b1, 2'b00, 1'b0, 1'b0);
        chk("t4_sel", 32'(a_sel), 32'b1110);
        chk("t4_sv", 32'(a_sv), 1);
        repeat (2) tick();
        chk("t4_dp_single", 32'(a_dp), 0);
        chk("t4_sv_held", 32'(a_sv), 1);
        a_drive(1'b0, 2'b00, 1'b1, 1'b1);
        chk("t4_clr_sel", 32'(a_sel), 0);
        chk("t4_clr_sv", 32'(a_sv), 0);
        tick();

        // Asynchronous reset between edges
        a_drive(1'b1, 2'b01, 1'b0, 1'b0);
        #2;
        clr = 1'b1;
        #1;
        chk("t5_sel", 32'(a_sel), 0);
        chk("t5_idx", 32'(a_idx), 0);
        chk("t5_busy", 32'(a_busy), 0);
        chk("t5_sv", 32'(a_sv), 0);
        tick();
        clr = 1'b0;
        tick();
        a_drive(1'b1, 2'b01, 1'b0, 1'b0);
        a_push(K_SEL, 32'b1001, 1);
        a_drive(1'b1, 2'b10, 1'b0, 1'b0);
        chk("t5_resume", 32'(a_sel), 32'b1001);
        a_drive(1'b0, 2'b00, 1'b0, 1'b1);

        // Three-field, 4-bit configuration
        chk("t6_idx0", 32'(b_idx), 0);
        b_drive(1'b1, 4'hA, 1'b0);
        chk("t6_idx1", 32'(b_idx), 1);
        chk("t6_live1", 32'(b_sel), 32'h00A);
        b_drive(1'b1, 4'h5, 1'b0);
        chk("t6_idx2", 32'(b_idx), 2);
        chk("t6_live2", 32'(b_sel), 32'h05A);
        eb.kind = K_SEL; eb.data = 32'hC5A; eb.at = cyc + 1;
        qb.push_back(eb);
        b_drive(1'b1, 4'hC, 1'b0);
        chk("t6_idx3", 32'(b_idx), 0);
        chk("t6_sv", 32'(b_sv), 1);
        b_drive(1'b0, 4'h0, 1'b1);
        chk("t6_ack", 32'(b_sv), 0);

        repeat (3) tick();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_selection_capture
`default_nettype wire
